pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding and default timing constants for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 100000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRY     = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - sequences PLL reset, lock qualification and downstream reset release
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count,
    output logic [2:0] state_o
);

    localparam int CNT_W   = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)) + 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock is the first of the qualifying run.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
    logic [7:0]           loss_count_q, loss_count_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 sys_rst_n_q, sys_rst_n_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;
    logic                 cnt_clr;
    logic                 locked_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST_ASSERT;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_count_q <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_count_q <= loss_count_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        retry_d      = retry_q;
        loss_count_d = loss_count_q;
        retry_inc    = retry_q + RETRY_W'(1);
        if (req_reset) begin
            state_d = ST_RST_ASSERT;
            cnt_clr = 1'b1;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RST_ASSERT: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_clr = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_clr = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_clr = 1'b1;
                        state_d = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RST_ASSERT;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_clr = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RST_ASSERT;
                        cnt_clr = 1'b1;
                        if (loss_count_q != 8'hFF) begin
                            loss_count_d = loss_count_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RST_ASSERT;
                    cnt_clr = 1'b1;
                end
            endcase
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((state_q == ST_RST_ASSERT) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state so every one of them is a clean flop.
    always_comb begin
        pll_rst_d   = (state_d == ST_RST_ASSERT);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign loss_count = loss_count_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] loss_count;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (50),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .req_reset  (req_reset),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .loss_count (loss_count),
        .state_o    (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (pll_rst === 1'b0 && fail === 1'b0 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_sys(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sys_rst_n !== lvl && n < 200);
    endtask

    initial begin
        int n, n2, highs;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_sys_rst_n", int'(sys_rst_n), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_loss", int'(loss_count), 0);
        check("rst_state", int'(state_o), int'(ST_RST_ASSERT));

        rst_n = 1'b1;
        measure_high(n);
        check("init_pulse_len", n, 4);

        repeat (10) tick();
        check("nom_wait_state", int'(state_o), int'(ST_WAIT_LOCK));
        pll_locked = 1'b1;
        wait_sys(1'b1, n);
        check("nom_release_lat", n, 10);
        check("nom_ready", int'(ready), 1);
        check("nom_state", int'(state_o), int'(ST_RUN));

        pll_locked = 1'b0;
        tick();
        tick();
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        check("simul_state", int'(state_o), int'(ST_RST_ASSERT));
        check("simul_loss", int'(loss_count), 0);
        check("simul_sys_rst_n", int'(sys_rst_n), 0);
        measure_high(n);
        check("simul_pulse_len", n, 4);
        pll_locked = 1'b1;
        wait_sys(1'b1, n);
        check("simul_relock_lat", n, 10);

        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_sys(1'b0, n);
            check("loss_deassert_lat", n, 3);
            measure_high(n);
            check("loss_pulse_len", n, 4);
            pll_locked = 1'b1;
            wait_sys(1'b1, n);
            check("loss_relock_lat", n, 10);
        end
        check("loss_count_sat", int'(loss_count), 255);

        pll_locked = 1'b0;
        wait_sys(1'b0, n);
        measure_high(n);
        pll_locked = 1'b1;
        repeat (6) tick();
        check("glitch_pre_state", int'(state_o), int'(ST_STABLE));
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        tick();
        check("glitch_state", int'(state_o), int'(ST_WAIT_LOCK));
        check("glitch_sys_rst_n", int'(sys_rst_n), 0);
        wait_sys(1'b1, n2);
        check("glitch_release_lat", 2 + n2, 10);

        req_reset  = 1'b1;
        pll_locked = 1'b0;
        tick();
        req_reset  = 1'b0;
        check("req_state", int'(state_o), int'(ST_RST_ASSERT));
        measure_high(n);
        check("req_pulse_len", n, 4);
        repeat (10) tick();
        check("async_pre_state", int'(state_o), int'(ST_WAIT_LOCK));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst", int'(pll_rst), 1);
        check("async_sys_rst_n", int'(sys_rst_n), 0);
        check("async_ready", int'(ready), 0);
        check("async_fail", int'(fail), 0);
        check("async_loss", int'(loss_count), 0);
        check("async_state", int'(state_o), int'(ST_RST_ASSERT));
        #2;
        rst_n = 1'b1;
        measure_high(n);
        check("async_pulse_len", n, 4);

        measure_low(n);
        check("timeout_gap1", n, 50);
        measure_high(n);
        check("timeout_pulse2", n, 4);
        measure_low(n);
        check("timeout_gap2", n, 50);
        check("timeout_fail", int'(fail), 1);
        check("timeout_state", int'(state_o), int'(ST_FAIL));
        check("timeout_sys_rst_n", int'(sys_rst_n), 0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pll_rst !== 1'b0) highs++;
        end
        check("fail_pll_rst_quiet", highs, 0);
        check("fail_hold", int'(fail), 1);

        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        check("recover_fail", int'(fail), 0);
        check("recover_state", int'(state_o), int'(ST_RST_ASSERT));
        measure_high(n);
        check("recover_pulse_len", n, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
